mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port data RAM between the instruction-fetch requester (IF) and the load/store requester (LS) of the multi-cycle RV32I core.
- Replaces the separate ROM/RAM paths so code and data live in one word-addressed array.
- One transaction is outstanding at a time. LS has priority over IF. A starvation counter guarantees IF forward progress.

Parameters:
ADDR_W, 7, RAM word-address width (byte address bits [ADDR_W+1:2])
RD_LAT, 1, cycles from ram_addr valid to ram_rdata valid; legal range 1..4
STARVE_MAX, 4, consecutive LS grants with IF pending before IF is forced; legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
if_req  in  1  IF read request; held with if_addr until if_gnt
if_addr  in  ADDR_W  IF word address
if_gnt  out  1  IF request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  IF read data; held until next IF read completes
ls_req  in  1  LS request; held with ls_* until ls_gnt
ls_we  in  1  1 = write, 0 = read
ls_be  in  4  write byte enables
ls_addr  in  ADDR_W  LS word address
ls_wdata  in  32  LS write data
ls_gnt  out  1  LS request accepted this cycle
ls_rvalid  out  1  one-cycle pulse: ls_rdata valid (reads only)
ls_rdata  out  32  LS read data; held until next LS read completes
ram_wren  out  1  RAM write strobe
ram_be  out  4  RAM byte enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE and the starvation counter clears.
  - All outputs go to 0: gnt, rvalid, rdata, ram_* outputs.
  - Any in-flight transaction is dropped and no rvalid is issued for it.
  - Operation resumes in IDLE on the first clk edge after rst falls.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Grants are combinational from the req inputs, asserted only in IDLE, at most one per cycle.
  - Selection rule: IF is granted if if_req is set and either ls_req is clear or starve_cnt equals STARVE_MAX. Otherwise LS is granted if ls_req is set.
  - On grant, the arbiter captures the requester ID, we, be, addr and wdata, and moves to ACCESS. IF requests are always reads (we=0).
- Starvation counter (4 bits):
  - Increments on an LS grant while if_req=1.
  - Clears on an IF grant, or on any IDLE cycle with if_req=0.
  - Saturates at STARVE_MAX.
- ACCESS (1 cycle):
  - ram_addr, ram_be and ram_wdata are registered from the captured request.
  - ram_wren=1 only for LS writes; it is 0 in every other state and cycle.
  - Writes go to IDLE next; no response is returned.
  - Reads go to WAIT.
  - ram_be is passed through unmodified; be=0 still pulses ram_wren.
- WAIT:
  - Lasts RD_LAT cycles (down-counter).
  - In the last WAIT cycle, ram_rdata is registered into the captured requester's rdata register; the other requester's rdata is unchanged.
  - Then go to RESP.
- RESP (1 cycle): the captured requester's rvalid=1, then go to IDLE.
- Latency from grant in cycle n:
  - Write: ram_wren in cycle n+1; next grant possible in n+2.
  - Read: rvalid in cycle n+2+RD_LAT; next grant possible in n+3+RD_LAT.
- ram_addr, ram_be and ram_wdata hold their last values outside ACCESS.
- Requests changing or dropping before gnt are legal; arbitration uses the current-cycle inputs.
- Requests arriving during ACCESS, WAIT or RESP wait for IDLE. No queuing beyond the requester's own hold.

Test Plan:
- Reset mid-read: IF read, rst pulsed during WAIT -> no if_rvalid, ram_wren=0, if_rdata=0; the next IF read completes normally.
- IF read alone, RD_LAT=1, RAM[5]=0xDEADBEEF: if_addr=5 -> if_gnt in cycle 0, ram_addr=5 in cycle 1, if_rvalid with if_rdata=0xDEADBEEF in cycle 3, ls_rvalid stays 0.
- LS write then read: ls_we=1, be=4'b0011, addr=9, wdata=0x12345678 -> ram_wren=1 for exactly one cycle with be=0011. Following read of addr 9 -> ls_rvalid with ls_rdata equal to the RAM model contents.
- Simultaneous requests: if_req and ls_req both set in IDLE -> ls_gnt=1, if_gnt=0. After LS completes, IF is granted if ls_req has dropped.
- Starvation, STARVE_MAX=4: ls_req held high with back-to-back reads, if_req high -> 4 LS grants, then 1 IF grant, then LS resumes; the counter observed cleared after the IF grant.
- RD_LAT=3 sweep: LS read -> ls_rvalid exactly 5 cycles after ls_gnt; if_rdata unchanged throughout.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and load/store, LS first with IF anti-starvation
module mem_arbiter #(
   parameter int ADDR_W     = 7,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [3:0]        ls_be,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [31:0]       ls_rdata,
   output logic              ram_wren,
   output logic [3:0]        ram_be,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
   state_t      r_state;
   logic        r_ls;
   logic        r_we;
   logic [3:0]  r_starve;
   logic [1:0]  r_lat;
   logic        w_idle;
   logic        w_if_sel;
   assign w_idle   = (r_state == IDLE) && !rst;
   assign w_if_sel = if_req && (!ls_req || r_starve == 4'(STARVE_MAX));
   assign if_gnt   = w_idle && w_if_sel;
   assign ls_gnt   = w_idle && ls_req && !w_if_sel;
   // arbitration, request capture, RAM drive and response sequencing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ls      <= 1'b0;
         r_we      <= 1'b0;
         r_starve  <= '0;
         r_lat     <= '0;
         if_rvalid <= 1'b0;
         if_rdata  <= '0;
         ls_rvalid <= 1'b0;
         ls_rdata  <= '0;
         ram_wren  <= 1'b0;
         ram_be    <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         ram_wren  <= 1'b0;
         if_rvalid <= 1'b0;
         ls_rvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_starve <= (if_gnt || !if_req) ? 4'd0 :
                           (ls_gnt && r_starve != 4'(STARVE_MAX)) ? r_starve + 4'd1 : r_starve;
               if (if_gnt || ls_gnt) begin
                  r_ls      <= ls_gnt;
                  r_we      <= ls_gnt && ls_we;
                  ram_wren  <= ls_gnt && ls_we;
                  ram_be    <= ls_gnt ? ls_be : 4'd0;
                  ram_addr  <= ls_gnt ? ls_addr : if_addr;
                  ram_wdata <= ls_gnt ? ls_wdata : 32'd0;
                  r_state   <= ACCESS;
               end
            end
            ACCESS: begin
               r_lat   <= 2'(RD_LAT - 1);
               r_state <= r_we ? IDLE : WAIT;
            end
            WAIT: begin
               r_lat <= r_lat - 2'd1;
               if (r_lat == 2'd0) begin
                  r_state   <= RESP;
                  ls_rvalid <= r_ls;
                  if_rvalid <= !r_ls;
                  ls_rdata  <= r_ls ? ram_rdata : ls_rdata;
                  if_rdata  <= r_ls ? if_rdata : ram_rdata;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: two arbiters (read latency 1 and 3) against a transaction-level reference model
module tb_mem_arbiter;
   localparam int SM = 4;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      return i == 5 ? 32'hDEADBEEF : i == 9 ? 32'hAABBCCDD : 32'h1000_0000 + 32'(i) * 32'h0101_0103;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int LAT = g ? 3 : 1;
      logic        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid, ram_wren;
      logic [6:0]  if_addr, ls_addr, ram_addr;
      logic [3:0]  ls_be, ram_be;
      logic [31:0] if_rdata, ls_wdata, ls_rdata, ram_wdata, ram_rdata;
      logic [31:0] ram [128];
      logic [31:0] pipe [4];
      bit          ram_ok = 1'b0;
      bit          done = 1'b0;

      mem_arbiter #(.ADDR_W(7), .RD_LAT(LAT), .STARVE_MAX(SM)) dut (
         .clk(clk), .rst(rst),
         .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
         .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
         .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
         .ram_wren(ram_wren), .ram_be(ram_be), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
      );

      // environment RAM: byte-enable writes, LAT-cycle read pipeline
      assign ram_rdata = pipe[LAT-1];
      always @(posedge clk) begin
         if (!ram_ok) begin
            for (int i = 0; i < 128; i++) ram[i] <= init_word(i);
            ram_ok <= 1'b1;
         end else if (ram_wren)
            for (int b = 0; b < 4; b++) if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         pipe[0] <= ram[ram_addr];
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end

      // reference model: one pending transaction, timing from grant-cycle arithmetic
      int          cyc = 0, t0 = 0, st = 0;
      bit          pv, pls, pwe, acc, rv, idle, gi, gl;
      logic [3:0]  pbe, e_be;
      logic [6:0]  pa, e_addr;
      logic [31:0] pwd, e_wd, e_ifd, e_lsd;
      logic [31:0] rm [128];
      initial begin
         for (int i = 0; i < 128; i++) rm[i] = init_word(i);
         pv = 0; e_addr = 0; e_ifd = 0; e_lsd = 0;
         forever begin
            @(negedge clk);
            acc = 0; rv = 0; gi = 0; gl = 0;
            if (rst) begin
               pv = 0; st = 0; e_ifd = 0; e_lsd = 0; e_addr = 0;
            end else begin
               acc = pv && cyc == t0 + 1;
               rv  = pv && !pwe && cyc == t0 + 2 + LAT;
               if (acc) begin
                  e_addr = pa; e_be = pbe; e_wd = pwd;
                  if (pwe) for (int b = 0; b < 4; b++) if (pbe[b]) rm[pa][8*b +: 8] = pwd[8*b +: 8];
               end
               if (rv && pls) e_lsd = rm[pa];
               if (rv && !pls) e_ifd = rm[pa];
               idle = !pv || cyc >= t0 + (pwe ? 2 : 3 + LAT);
               if (idle) begin
                  gi = if_req && (!ls_req || st == SM);
                  gl = ls_req && !gi;
                  st = (gi || !if_req) ? 0 : (gl && st < SM) ? st + 1 : st;
                  pv = gi || gl;
                  if (pv) begin
                     t0 = cyc; pls = gl; pwe = gl && ls_we; pbe = ls_be;
                     pa = gl ? ls_addr : if_addr; pwd = ls_wdata;
                  end
               end
            end
            cyc++;
            chk("if_gnt", 32'(if_gnt), 32'(gi));
            chk("ls_gnt", 32'(ls_gnt), 32'(gl));
            chk("ram_wren", 32'(ram_wren), 32'(acc && pwe));
            chk("if_rvalid", 32'(if_rvalid), 32'(rv && !pls));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(rv && pls));
            chk("if_rdata", if_rdata, e_ifd);
            chk("ls_rdata", ls_rdata, e_lsd);
            chk("ram_addr", 32'(ram_addr), 32'(e_addr));
            if (acc && pwe) begin
               chk("ram_be", 32'(ram_be), 32'(e_be));
               chk("ram_wdata", ram_wdata, e_wd);
            end
         end
      end

      task automatic await_gnt(input bit ls);
         bit ok = 0;
         for (int k = 0; k < 64 && !ok; k++) begin
            @(negedge clk);
            ok = ls ? ls_gnt : if_gnt;
            if (!ok) begin @(posedge clk); #1; end
         end
         chk(ls ? "ls_gnt_wait" : "if_gnt_wait", 32'(ok), 32'd1);
         @(posedge clk); #1;
         if (ls) ls_req = 0; else if_req = 0;
      endtask

      task automatic await_rv(input bit ls);
         bit hit = 0;
         int n = 1;
         while (!hit && n < 20) begin
            @(negedge clk);
            hit = ls ? ls_rvalid : if_rvalid;
            if (!hit) begin @(posedge clk); #1; n++; end
         end
         chk("rv_latency", 32'(n), 32'(LAT + 2));
      endtask

      logic [9:0] seq;
      bit         sgi, sgl;
      // directed scenarios followed by random traffic
      initial begin
         if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
         #2;
         @(negedge rst);
         if_req = 1; if_addr = 7'd5;
         await_gnt(0);
         @(posedge rst);
         @(negedge clk);
         chk("rst_if_rdata", if_rdata, 32'd0);
         chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
         chk("rst_ram_wren", 32'(ram_wren), 32'd0);
         @(negedge rst);
         if_req = 1; if_addr = 7'd5;
         await_gnt(0);
         await_rv(0);
         chk("if_read5", if_rdata, 32'hDEADBEEF);
         chk("if_read5_ls_rv", 32'(ls_rvalid), 32'd0);
         @(posedge clk); #1;
         ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 7'd9; ls_wdata = 32'h12345678;
         await_gnt(1);
         @(negedge clk);
         chk("wr_wren", 32'(ram_wren), 32'd1);
         chk("wr_be", 32'(ram_be), 32'h3);
         chk("wr_addr", 32'(ram_addr), 32'd9);
         @(posedge clk); #1;
         @(negedge clk);
         chk("wr_wren_once", 32'(ram_wren), 32'd0);
         @(posedge clk); #1;
         ls_req = 1; ls_we = 0; ls_addr = 7'd9;
         await_gnt(1);
         await_rv(1);
         chk("ls_read9", ls_rdata, 32'hAABB5678);
         @(posedge clk); #1;
         if_req = 1; if_addr = 7'd1; ls_req = 1; ls_we = 0; ls_addr = 7'd2;
         @(negedge clk);
         chk("both_ls_gnt", 32'(ls_gnt), 32'd1);
         chk("both_if_gnt", 32'(if_gnt), 32'd0);
         @(posedge clk); #1;
         ls_req = 0;
         await_gnt(0);
         await_rv(0);
         chk("if_read1", if_rdata, 32'h11010103);
         @(posedge clk); #1;
         if_req = 1; if_addr = 7'd3; ls_req = 1; ls_we = 0; ls_addr = 7'd4;
         seq = 0;
         for (int n = 0; n < 10; n++) begin
            sgi = 0; sgl = 0;
            for (int k = 0; k < 40 && !(sgi || sgl); k++) begin
               @(negedge clk);
               sgi = if_gnt; sgl = ls_gnt;
               if (!(sgi || sgl)) begin @(posedge clk); #1; end
            end
            seq = {seq[8:0], sgi};
            @(posedge clk); #1;
         end
         chk("starve_seq", 32'(seq), 32'(10'b0000100001));
         if_req = 0; ls_req = 0;
         for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            sgi = if_gnt; sgl = ls_gnt;
            @(posedge clk); #1;
            if (sgi) if_req = 0;
            if (sgl) ls_req = 0;
            if (!if_req && $urandom_range(3) == 0) begin
               if_req = 1; if_addr = 7'($urandom_range(15));
            end
            if (!ls_req && $urandom_range(2) == 0) begin
               ls_req = 1; ls_we = 1'($urandom_range(1)); ls_be = 4'($urandom);
               ls_addr = 7'($urandom_range(15)); ls_wdata = $urandom;
            end
         end
         if_req = 0; ls_req = 0;
         repeat (12) @(posedge clk);
         done = 1;
      end
   end

   initial begin
      rst = 0;
      #1 rst = 1;
      repeat (3) @(posedge clk);
      #2 rst = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1;
      @(posedge clk);
      #2 rst = 0;
      for (int k = 0; k < 60000 && !(lane[0].done && lane[1].done); k++) @(posedge clk);
      chk("finish_timeout", 32'(lane[0].done && lane[1].done), 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
